// File: rtl/dm_pkg.sv
// Shared types and constants for the handshaked data memory (dm_hs) and its lane steering unit.
package dm_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_HS = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_BS = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
    } req_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_BU;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for stores and sign/zero extension for loads; purely combinational.
// Illegal op codes leave the word untouched and return zero load data (fault is decided by the caller).
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  a_lo,
    input  logic [31:0] wd,
    input  logic [31:0] old_word,
    output logic [31:0] st_word,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign b_sh = {a_lo, 3'b000};
    assign h_sh = {a_lo[1], 4'b0000};

    always_comb begin
        ld_b     = old_word[b_sh +: 8];
        ld_h     = old_word[h_sh +: 16];
        st_word  = old_word;
        ld_data  = '0;
        misalign = 1'b0;
        case (op)
            OP_W: begin
                misalign = |a_lo;
                st_word  = wd;
                ld_data  = old_word;
            end
            OP_HS, OP_HU: begin
                misalign             = a_lo[0];
                st_word[h_sh +: 16]  = wd[15:0];
                ld_data              = {{16{(op == OP_HS) & ld_h[15]}}, ld_h};
            end
            OP_BS, OP_BU: begin
                st_word[b_sh +: 8] = wd[7:0];
                ld_data            = {{24{(op == OP_BS) & ld_b[7]}}, ld_b};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_hs.sv
// Word RAM behind a req/ack handshake: Ack WAIT+1 cycles after accept, Ready low while busy (Req ignored).
// Misaligned/illegal ops fault without writing; DM_RANGE_CHECK_EN also faults addresses outside the mapped window.
module dm_hs
    import dm_pkg::*;
#(
    parameter int          ADDR_W = 11,
    parameter int          WAIT   = 1,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        We,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic        Ready,
    output logic        Ack,
    output logic [31:0] RD,
    output logic        Fault
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    state_t            state;
    req_t              req_q;
    logic [CNT_W-1:0]  cnt;

    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word;
    logic [31:0]       st_word;
    logic [31:0]       ld_data;
    logic              misalign;
    logic              out_of_range;
    logic              fault;

    assign off      = req_q.a - BASE;
    assign idx      = off[ADDR_W+1:2];
    assign old_word = mem[idx];

`ifdef DM_RANGE_CHECK_EN
    // Offset is unsigned, so addresses below BASE wrap high and are caught here too.
    assign out_of_range = |off[31:ADDR_W+2];
    logic unused_off;
    assign unused_off = ^off[1:0];
`else
    assign out_of_range = 1'b0;
    logic unused_off;
    assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};
`endif

    assign fault = misalign | ~op_legal(req_q.op) | out_of_range;

    dm_lane u_lane (
        .op       (req_q.op),
        .a_lo     (req_q.a[1:0]),
        .wd       (req_q.wd),
        .old_word (old_word),
        .st_word  (st_word),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    // No reset on the array: contents survive Reset, and Reset on the DONE edge suppresses the write.
    always_ff @(posedge Clk) begin
        if (!Reset && state == S_DONE && req_q.we && !fault) begin
            mem[idx] <= st_word;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            req_q <= '0;
            cnt   <= '0;
            Ready <= 1'b1;
            Ack   <= 1'b0;
            RD    <= '0;
            Fault <= 1'b0;
        end else begin
            Ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Req) begin
                        req_q <= '{we: We, op: Op, a: A, wd: WD};
                        Ready <= 1'b0;
                        cnt   <= CNT_W'(WAIT);
                        state <= (WAIT > 0) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    Ack   <= 1'b1;
                    Fault <= fault;
                    if (!req_q.we && !fault) begin
                        RD <= ld_data;
                    end
                    Ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_hs.sv
// Bench for dm_hs: a WAIT=1 instance for data/fault/reset scenarios, a WAIT=0 instance for streaming.
module tb_dm_hs;
    import dm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req1, req0, we;
    logic [2:0]  op;
    logic [31:0] a, wd;
    logic        ready1, ack1, fault1, ready0, ack0, fault0;
    logic [31:0] rd1, rd0;

    dm_hs #(.ADDR_W(11), .WAIT(1), .BASE(32'h0)) u_dut1 (
        .Clk(clk), .Reset(reset), .Req(req1), .We(we), .Op(op), .A(a), .WD(wd),
        .Ready(ready1), .Ack(ack1), .RD(rd1), .Fault(fault1)
    );

    dm_hs #(.ADDR_W(11), .WAIT(0), .BASE(32'h0)) u_dut0 (
        .Clk(clk), .Reset(reset), .Req(req0), .We(we), .Op(op), .A(a), .WD(wd),
        .Ready(ready0), .Ack(ack0), .RD(rd0), .Fault(fault0)
    );

    typedef struct {
        logic [31:0] rd;
        logic        flt;
    } exp_t;

    typedef struct {
        logic        w;
        logic [2:0]  o;
        logic [31:0] ad;
        logic [31:0] d;
        logic [31:0] rd;
        logic        flt;
    } step_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd_hold  = 32'h0;

    // Drive one request on the WAIT=1 instance and return what came back with its Ack.
    task automatic access1(input logic w, input logic [2:0] o, input logic [31:0] ad,
                           input logic [31:0] d, output int lat,
                           output logic [31:0] r, output logic f);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        we = w; op = o; a = ad; wd = d; req1 = 1'b1;
        @(posedge clk);
        #1 req1 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ack1 && lat < 40);
        r = rd1;
        f = fault1;
    endtask

    function automatic exp_t expect_of(input step_t s);
        exp_t e;
        e.flt = s.flt;
        e.rd  = (!s.w && !s.flt) ? s.rd : rd_hold;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; req1 = 1'b0; req0 = 1'b0;
        we = 1'b0; op = OP_W; a = '0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 6;
        if (ready1 !== 1'b1) begin n_fail++; $display("FAIL reset ready1: got %b want 1", ready1); end
        if (ack1 !== 1'b0) begin n_fail++; $display("FAIL reset ack1: got %b want 0", ack1); end
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset rd1: got %h want 0", rd1); end
        if (fault1 !== 1'b0) begin n_fail++; $display("FAIL reset fault1: got %b want 0", fault1); end
        if (ready0 !== 1'b1) begin n_fail++; $display("FAIL reset ready0: got %b want 1", ready0); end
        if (ack0 !== 1'b0) begin n_fail++; $display("FAIL reset ack0: got %b want 0", ack0); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lanes();
        step_t st[18];
        int lat; logic [31:0] r; logic f; exp_t e;
        st = '{
            '{1'b1, OP_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, OP_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, OP_W,  32'h10, 32'h0,        32'h0,        1'b0},
            '{1'b1, OP_BU, 32'h13, 32'h00000080, 32'h0,        1'b0},
            '{1'b0, OP_BS, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0},
            '{1'b0, OP_BU, 32'h13, 32'h0,        32'h00000080, 1'b0},
            '{1'b0, OP_W,  32'h10, 32'h0,        32'h80000000, 1'b0},
            '{1'b1, OP_HS, 32'h22, 32'h00001234, 32'h0,        1'b0},
            '{1'b0, OP_HS, 32'h22, 32'h0,        32'h00001234, 1'b0},
            '{1'b0, OP_W,  32'h20, 32'h0,        32'h12340000, 1'b0},
            '{1'b0, OP_HU, 32'h20, 32'h0,        32'h00000000, 1'b0},
            '{1'b1, OP_HU, 32'h20, 32'hFFFF8001, 32'h0,        1'b0},
            '{1'b0, OP_HS, 32'h20, 32'h0,        32'hFFFF8001, 1'b0},
            '{1'b0, OP_HU, 32'h20, 32'h0,        32'h00008001, 1'b0},
            '{1'b0, OP_W,  32'h20, 32'h0,        32'h12348001, 1'b0},
            '{1'b1, OP_BS, 32'h21, 32'h555555AB, 32'h0,        1'b0},
            '{1'b0, OP_BU, 32'h21, 32'h0,        32'h000000AB, 1'b0},
            '{1'b0, OP_W,  32'h20, 32'h0,        32'h1234AB01, 1'b0}
        };
        foreach (st[i]) begin
            e = expect_of(st[i]);
            sb.push_back(e);
            rd_hold = e.rd;
            access1(st[i].w, st[i].o, st[i].ad, st[i].d, lat, r, f);
            e = sb.pop_front();
            n_checks += 3;
            if (lat !== 2) begin n_fail++; $display("FAIL lanes[%0d] latency: got %0d want 2", i, lat); end
            if (r !== e.rd) begin n_fail++; $display("FAIL lanes[%0d] rd: got %h want %h", i, r, e.rd); end
            if (f !== e.flt) begin n_fail++; $display("FAIL lanes[%0d] fault: got %b want %b", i, f, e.flt); end
        end
    endtask

    task automatic test_fault();
        step_t st[10];
        int lat; logic [31:0] r; logic f; exp_t e;
        st = '{
            '{1'b1, OP_W,  32'h51, 32'hCAFEF00D, 32'h0,        1'b1},
            '{1'b0, OP_W,  32'h50, 32'h0,        32'h00000000, 1'b0},
            '{1'b0, OP_W,  32'h52, 32'h0,        32'h0,        1'b1},
            '{1'b0, OP_HS, 32'h23, 32'h0,        32'h0,        1'b1},
            '{1'b1, OP_HU, 32'h21, 32'h0000FFFF, 32'h0,        1'b1},
            '{1'b0, OP_W,  32'h20, 32'h0,        32'h1234AB01, 1'b0},
            '{1'b0, 3'b101, 32'h20, 32'h0,       32'h0,        1'b1},
            '{1'b1, 3'b111, 32'h20, 32'h0,       32'h0,        1'b1},
            '{1'b0, OP_W,  32'h20, 32'h0,        32'h1234AB01, 1'b0},
            '{1'b0, OP_W,  32'h50, 32'h0,        32'h00000000, 1'b0}
        };
        foreach (st[i]) begin
            e = expect_of(st[i]);
            sb.push_back(e);
            rd_hold = e.rd;
            access1(st[i].w, st[i].o, st[i].ad, st[i].d, lat, r, f);
            e = sb.pop_front();
            n_checks += 3;
            if (lat !== 2) begin n_fail++; $display("FAIL fault[%0d] latency: got %0d want 2", i, lat); end
            if (r !== e.rd) begin n_fail++; $display("FAIL fault[%0d] rd: got %h want %h", i, r, e.rd); end
            if (f !== e.flt) begin n_fail++; $display("FAIL fault[%0d] fault: got %b want %b", i, f, e.flt); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        @(negedge clk);
        we = 1'b0; op = OP_W; a = 32'h10; wd = '0; req0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            exp_ack = (i % 2) == 1;
            n_checks += 2;
            if (ack0 !== exp_ack) begin n_fail++; $display("FAIL b2b[%0d] ack0: got %b want %b", i, ack0, exp_ack); end
            if (ready0 !== exp_ack) begin n_fail++; $display("FAIL b2b[%0d] ready0: got %b want %b", i, ready0, exp_ack); end
        end
        n_checks += 1;
        if (rd0 !== 32'h0 || fault0 !== 1'b0) begin
            n_fail++; $display("FAIL b2b data: got rd %h fault %b want 0/0", rd0, fault0);
        end
        @(negedge clk);
        req0 = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        step_t st[3];
        int lat; int acks; logic [31:0] r; logic f; exp_t e;
        // Reset while the store sits in WAIT, then while it sits in DONE.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            we = 1'b1; op = OP_W; a = (k == 0) ? 32'h40 : 32'h44; wd = 32'h12345678; req1 = 1'b1;
            @(posedge clk);
            #1 req1 = 1'b0;
            n_checks += 1;
            if (ready1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid[%0d] accept ready1: got %b want 0", k, ready1); end
            if (k == 1) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            n_checks += 3;
            if (ack1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid[%0d] ack1: got %b want 0", k, ack1); end
            if (ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_mid[%0d] ready1: got %b want 1", k, ready1); end
            if (rd1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid[%0d] rd1: got %h want 0", k, rd1); end
            @(negedge clk);
            reset = 1'b0;
            acks = 0;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (ack1) acks++;
            end
            n_checks += 1;
            if (acks !== 0) begin n_fail++; $display("FAIL rst_mid[%0d] stray acks: got %0d want 0", k, acks); end
        end
        rd_hold = 32'h0;
        st = '{
            '{1'b0, OP_W, 32'h40,   32'h0, 32'h0, 1'b0},
            '{1'b0, OP_W, 32'h44,   32'h0, 32'h0, 1'b0},
`ifdef DM_RANGE_CHECK_EN
            '{1'b0, OP_W, 32'h2000, 32'h0, 32'h0, 1'b1}
`else
            '{1'b0, OP_W, 32'h2000, 32'h0, 32'h0, 1'b0}
`endif
        };
        foreach (st[i]) begin
            e = expect_of(st[i]);
            sb.push_back(e);
            rd_hold = e.rd;
            access1(st[i].w, st[i].o, st[i].ad, st[i].d, lat, r, f);
            e = sb.pop_front();
            n_checks += 3;
            if (lat !== 2) begin n_fail++; $display("FAIL rst_load[%0d] latency: got %0d want 2", i, lat); end
            if (r !== e.rd) begin n_fail++; $display("FAIL rst_load[%0d] rd: got %h want %h", i, r, e.rd); end
            if (f !== e.flt) begin n_fail++; $display("FAIL rst_load[%0d] fault: got %b want %b", i, f, e.flt); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lanes();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
